// File: rtl/fnd_display_arbiter_if.sv
// Bundles the display arbiter's data/handshake signals.
// master: the side that supplies digits and requests overlays.
// slave:  the arbiter itself, which drives the FND outputs.
interface fnd_display_arbiter_if;
    logic        sw_mode;     // 0 = stopwatch source, 1 = clock source
    logic [15:0] sw_digits;   // stopwatch nibbles, [3:0] is digit0 (rightmost)
    logic [15:0] clk_digits;  // clock nibbles, same packing
    logic        msg_req;     // overlay request, level-sampled
    logic [15:0] msg_digits;  // overlay nibbles, same packing
    logic [3:0]  dot_en;      // per-digit decimal point, 1 = lit
    logic        msg_ack;     // one-clk pulse when a request is latched
    logic        msg_busy;    // overlay pending or on screen
    logic [3:0]  digit_code;  // nibble for the segment decoder, 4'hF = blank
    logic        dp_n;        // decimal point, active-low
    logic [3:0]  fnd_comm;    // digit commons, active-low one-hot

    modport master (
        output sw_mode, sw_digits, clk_digits, msg_req, msg_digits, dot_en,
        input  msg_ack, msg_busy, digit_code, dp_n, fnd_comm
    );

    modport slave (
        input  sw_mode, sw_digits, clk_digits, msg_req, msg_digits, dot_en,
        output msg_ack, msg_busy, digit_code, dp_n, fnd_comm
    );
endinterface

// File: rtl/fnd_display_arbiter.sv
// 4-digit multiplexed FND driver that arbitrates between a base source
// (stopwatch or clock, chosen by sw_mode) and a timed message overlay.
// A blank scan slot is inserted on every source switch to avoid ghosting.
//
// Optional feature: define FND_LEADING_ZERO_BLANK_EN to blank leading zeros
// on digits 3 and 2 of the base source (the overlay is never modified).
module fnd_display_arbiter #(
    parameter int SCAN_DIV   = 100_000,  // clk cycles per scan slot, >= 2
    parameter int MSG_FRAMES = 100       // full 4-digit frames an overlay is held
) (
    input  logic                  clk,
    input  logic                  rst,
    fnd_display_arbiter_if.slave  bus
);

    localparam int PRESC_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int FRAME_W = $clog2(MSG_FRAMES + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(MSG_FRAMES);

    localparam logic [1:0] ST_BASE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_MSG   = 2'd2;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [PRESC_W-1:0] presc_q;
    logic [1:0]         scan_idx_q;
    logic               tick;
    logic               frame_end;

    assign tick      = (presc_q == PRESC_LAST);
    assign frame_end = tick && (scan_idx_q == 2'd3);

    // Prescaler and digit index: one slot per SCAN_DIV clocks, wrap 3->0 ends a frame.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; a blocking = here would let later statements see
    // already-updated state and break the ordering between registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            scan_idx_q <= 2'd0;
        end else if (tick) begin
            presc_q    <= '0;
            scan_idx_q <= scan_idx_q + 2'd1;
        end else begin
            presc_q    <= presc_q + PRESC_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------
    logic [1:0]         state_q,  state_n;
    logic [1:0]         succ_q,   succ_n;     // where BLANK goes on the next tick
    logic [FRAME_W-1:0] frame_q,  frame_n;
    logic [FRAME_W-1:0] frame_inc;
    logic [15:0]        msg_q,    msg_n;
    logic               ack_n;
    logic               busy_q,   busy_n;
    logic               sw_mode_q;
    logic               ack_q;
    logic               refresh_q;            // outputs reload on the next clk

    assign frame_inc = frame_q + FRAME_W'(1);

    // Next-state logic: request handling, mode-change blanking, overlay timeout.
    // NOTE: every variable gets a default at the top of the block so that no
    // path leaves it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_n = state_q;
        succ_n  = succ_q;
        frame_n = frame_q;
        msg_n   = msg_q;
        ack_n   = 1'b0;
        busy_n  = busy_q;

        case (state_q)
            ST_BASE: begin
                // A request wins over a simultaneous mode change; the mode
                // copy still follows sw_mode, so the return shows the new source.
                if (bus.msg_req) begin
                    msg_n   = bus.msg_digits;
                    ack_n   = 1'b1;
                    busy_n  = 1'b1;
                    state_n = ST_BLANK;
                    succ_n  = ST_MSG;
                end else if (bus.sw_mode != sw_mode_q) begin
                    state_n = ST_BLANK;
                    succ_n  = ST_BASE;
                end
            end

            ST_BLANK: begin
                if (tick) begin
                    state_n = succ_q;
                    if (succ_q == ST_MSG) begin
                        frame_n = '0;
                    end else begin
                        busy_n  = 1'b0;
                    end
                end
            end

            ST_MSG: begin
                // A fresh request restarts the hold time without blanking.
                if (bus.msg_req) begin
                    msg_n   = bus.msg_digits;
                    ack_n   = 1'b1;
                    frame_n = '0;
                end else if (frame_end) begin
                    frame_n = frame_inc;
                    if (frame_inc == FRAME_LAST) begin
                        state_n = ST_BLANK;
                        succ_n  = ST_BASE;
                    end
                end
            end

            default: begin
                state_n = ST_BASE;
                succ_n  = ST_BASE;
                busy_n  = 1'b0;
            end
        endcase
    end

    // FSM and overlay registers; the mode copy tracks sw_mode every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_BASE;
            succ_q    <= ST_BASE;
            frame_q   <= '0;
            msg_q     <= 16'hFFFF;
            sw_mode_q <= bus.sw_mode;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            succ_q    <= succ_n;
            frame_q   <= frame_n;
            msg_q     <= msg_n;
            sw_mode_q <= bus.sw_mode;
            ack_q     <= ack_n;
            busy_q    <= busy_n;
            refresh_q <= tick || (state_n != state_q);
        end
    end

    // ------------------------------------------------------------------
    // Digit selection
    // ------------------------------------------------------------------
    logic [15:0] base_digits;
    logic [15:0] src_digits;
    logic [3:0]  nibble;

    // Pick the active source and the nibble for the current scan slot.
    always_comb begin
        base_digits = sw_mode_q ? bus.clk_digits : bus.sw_digits;
        src_digits  = (state_q == ST_MSG) ? msg_q : base_digits;

        case (scan_idx_q)
            2'd0:    nibble = src_digits[3:0];
            2'd1:    nibble = src_digits[7:4];
            2'd2:    nibble = src_digits[11:8];
            default: nibble = src_digits[15:12];
        endcase

`ifdef FND_LEADING_ZERO_BLANK_EN
        // Blank leading zeros of the base source only; digits 1 and 0 always show.
        if (state_q == ST_BASE) begin
            if ((scan_idx_q == 2'd3) && (base_digits[15:12] == 4'h0)) begin
                nibble = 4'hF;
            end else if ((scan_idx_q == 2'd2) && (base_digits[15:8] == 8'h00)) begin
                nibble = 4'hF;
            end
        end
`else
        // All nibbles pass through unmodified.
`endif
    end

    // ------------------------------------------------------------------
    // Registered display outputs
    // ------------------------------------------------------------------
    logic [3:0] fnd_comm_q;
    logic [3:0] digit_code_q;
    logic       dp_n_q;

    // Reload the display on the clk after a tick or a state change; blank reads as all-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fnd_comm_q   <= 4'b1111;
            digit_code_q <= 4'hF;
            dp_n_q       <= 1'b1;
        end else if (refresh_q) begin
            if (state_q == ST_BLANK) begin
                fnd_comm_q   <= 4'b1111;
                digit_code_q <= 4'hF;
                dp_n_q       <= 1'b1;
            end else begin
                fnd_comm_q   <= ~(4'b0001 << scan_idx_q);
                digit_code_q <= nibble;
                dp_n_q       <= (state_q == ST_BASE) ? ~bus.dot_en[scan_idx_q] : 1'b1;
            end
        end
    end

    assign bus.fnd_comm   = fnd_comm_q;
    assign bus.digit_code = digit_code_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.msg_ack    = ack_q;
    assign bus.msg_busy   = busy_q;

endmodule

// File: tb/tb_fnd_display_arbiter.sv
// Directed bench for fnd_display_arbiter with SCAN_DIV=4, MSG_FRAMES=2.
// Slot S is on screen from clk edge 4S+1 to 4S+4 after reset release;
// each slot is sampled 1 time unit after edge 4S+3.
module tb_fnd_display_arbiter;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_fail;

    fnd_display_arbiter_if u_if ();

    fnd_display_arbiter #(
        .SCAN_DIV   (4),
        .MSG_FRAMES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam logic [3:0] LZ = 4'hF;
`else
    localparam logic [3:0] LZ = 4'h0;
`endif

    // Active-low one-hot commons per scan index.
    logic [3:0] comm_t [4];
    // Expected overlay nibbles for 16'hABCD and 16'h9876, digit0 first.
    logic [3:0] abcd_t [4];
    logic [3:0] m9876_t [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_slot(input string tag, input logic [3:0] comm,
                              input logic [3:0] code, input logic dp);
        check({tag, ".comm"}, 16'(u_if.fnd_comm), 16'(comm));
        check({tag, ".code"}, 16'(u_if.digit_code), 16'(code));
        check({tag, ".dp_n"}, 16'(u_if.dp_n), 16'(dp));
    endtask

    task automatic check_blank(input string tag);
        check_slot(tag, 4'b1111, 4'hF, 1'b1);
    endtask

    // Advance to 1 time unit after clk edge number c.
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        comm_t   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        abcd_t   = '{4'hD, 4'hC, 4'hB, 4'hA};
        m9876_t  = '{4'h6, 4'h7, 4'h8, 4'h9};

        rst              = 1'b1;
        u_if.sw_mode     = 1'b1;
        u_if.sw_digits   = 16'h0045;
        u_if.clk_digits  = 16'h1234;
        u_if.msg_req     = 1'b0;
        u_if.msg_digits  = 16'h0000;
        u_if.dot_en      = 4'b0101;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_blank("reset");
        check("reset.ack", 16'(u_if.msg_ack), 16'h0);
        check("reset.busy", 16'(u_if.msg_busy), 16'h0);
        @(negedge clk);
        rst = 1'b0;

        // Base display of clk_digits=1234, blank until the first tick
        goto(3);  check_blank("s0");
        goto(7);  check_slot("s1", 4'b1101, 4'h3, 1'b1);
        goto(11); check_slot("s2", 4'b1011, 4'h2, 1'b0);
        goto(15); check_slot("s3", 4'b0111, 4'h1, 1'b1);
        goto(19); check_slot("s4", 4'b1110, 4'h4, 1'b0);

        // Overlay ABCD: request in a scan-2 slot so MSG starts on digit0
        goto(27);
        u_if.msg_req    = 1'b1;
        u_if.msg_digits = 16'hABCD;
        goto(28);
        check("m1.ack", 16'(u_if.msg_ack), 16'h1);
        check("m1.busy", 16'(u_if.msg_busy), 16'h1);
        u_if.msg_req = 1'b0;
        goto(29);
        check("m1.ack_low", 16'(u_if.msg_ack), 16'h0);
        goto(31); check_blank("m1.pre");
        for (int s = 8; s < 16; s++) begin
            goto(4 * s + 3);
            check_slot($sformatf("m1.s%0d", s), comm_t[s % 4], abcd_t[s % 4], 1'b1);
            check($sformatf("m1.s%0d.busy", s), 16'(u_if.msg_busy), 16'h1);
        end
        goto(67); check_blank("m1.post");
        check("m1.post.busy", 16'(u_if.msg_busy), 16'h1);
        goto(71); check_slot("m1.base", 4'b1101, 4'h3, 1'b1);
        check("m1.base.busy", 16'(u_if.msg_busy), 16'h0);

        // Mode switch 1->0: one blank slot, then stopwatch 0045
        goto(75); check_slot("s18", 4'b1011, 4'h2, 1'b0);
        u_if.sw_mode = 1'b0;
        goto(79); check_blank("sw0.blank");
        check("sw0.busy", 16'(u_if.msg_busy), 16'h0);
        goto(83); check_slot("sw0.d0", 4'b1110, 4'h5, 1'b0);
        goto(87); check_slot("sw0.d1", 4'b1101, 4'h4, 1'b1);
        goto(91); check_slot("sw0.d2", 4'b1011, LZ, 1'b0);
        goto(95); check_slot("sw0.d3", 4'b0111, LZ, 1'b1);

        // Mode switch 0->1: one blank slot, then clk_digits
        u_if.sw_mode = 1'b1;
        goto(99);  check_blank("sw1.blank");
        goto(103); check_slot("sw1.d1", 4'b1101, 4'h3, 1'b1);
        goto(107); check_slot("sw1.d2", 4'b1011, 4'h2, 1'b0);

        // Overlay, then re-request at the end of its second frame
        u_if.msg_req    = 1'b1;
        u_if.msg_digits = 16'hABCD;
        goto(108);
        check("m2.ack", 16'(u_if.msg_ack), 16'h1);
        u_if.msg_req = 1'b0;
        goto(111); check_blank("m2.pre");
        goto(115); check_slot("m2.s28", 4'b1110, 4'hD, 1'b1);
        goto(135); check_slot("m2.s33", 4'b1101, 4'hC, 1'b1);
        goto(143); check_slot("m2.s35", 4'b0111, 4'hA, 1'b1);
        u_if.msg_req    = 1'b1;
        u_if.msg_digits = 16'h9876;
        goto(144);
        check("m3.ack", 16'(u_if.msg_ack), 16'h1);
        u_if.msg_req = 1'b0;
        for (int s = 36; s < 44; s++) begin
            goto(4 * s + 3);
            check_slot($sformatf("m3.s%0d", s), comm_t[s % 4], m9876_t[s % 4], 1'b1);
        end
        goto(179); check_blank("m3.post");
        goto(183); check_slot("m3.base", 4'b1101, 4'h3, 1'b1);
        check("m3.base.busy", 16'(u_if.msg_busy), 16'h0);

        // Request and mode toggle in the same clk: request wins, new mode shown after
        goto(187); check_slot("s46", 4'b1011, 4'h2, 1'b0);
        u_if.msg_req    = 1'b1;
        u_if.sw_mode    = 1'b0;
        u_if.msg_digits = 16'h1357;
        goto(188);
        check("m4.ack", 16'(u_if.msg_ack), 16'h1);
        u_if.msg_req = 1'b0;
        goto(191); check_blank("m4.pre");
        goto(195); check_slot("m4.s48", 4'b1110, 4'h7, 1'b1);
        goto(211); check_slot("m4.s52", 4'b1110, 4'h7, 1'b1);
        goto(227); check_blank("m4.post");
        goto(231); check_slot("m4.base", 4'b1101, 4'h4, 1'b1);
        check("m4.base.busy", 16'(u_if.msg_busy), 16'h0);

        // Reset in the middle of an overlay discards it
        goto(235); check_slot("s58", 4'b1011, LZ, 1'b0);
        u_if.msg_req    = 1'b1;
        u_if.msg_digits = 16'hABCD;
        goto(236);
        check("m5.ack", 16'(u_if.msg_ack), 16'h1);
        u_if.msg_req = 1'b0;
        goto(243); check_slot("m5.s60", 4'b1110, 4'hD, 1'b1);
        goto(247); check_slot("m5.s61", 4'b1101, 4'hC, 1'b1);
        rst = 1'b1;
        #1;
        check_blank("rst2");
        check("rst2.busy", 16'(u_if.msg_busy), 16'h0);
        check("rst2.ack", 16'(u_if.msg_ack), 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        goto(3);  check_blank("rst2.s0");
        goto(7);  check_slot("rst2.s1", 4'b1101, 4'h4, 1'b1);
        check("rst2.s1.busy", 16'(u_if.msg_busy), 16'h0);
        goto(11); check_slot("rst2.s2", 4'b1011, LZ, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fnd_display_arbiter.md
FND_DISPLAY_ARBITER -- requirements
Module: fnd_display_arbiter

Interface
REQ-001 Parameter SCAN_DIV, default 100_000: clk cycles per scan slot; legal range 2 or more.
REQ-002 Parameter MSG_FRAMES, default 100: number of full 4-digit frames a message overlay is held.
REQ-003 clk  in  1  system clock.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 sw_mode  in  1  base source select: 0 = stopwatch, 1 = clock.
REQ-006 sw_digits  in  16  stopwatch nibbles; [3:0] is digit0 (rightmost) through [15:12] digit3.
REQ-007 clk_digits  in  16  clock nibbles, same packing as sw_digits.
REQ-008 msg_req  in  1  overlay request, level-sampled each clk.
REQ-009 msg_digits  in  16  overlay nibbles, same packing as sw_digits.
REQ-010 dot_en  in  4  per-digit decimal point enable; bit n is digit n, 1 = lit.
REQ-011 msg_ack  out  1  one-clk pulse when a request is latched.
REQ-012 msg_busy  out  1  high while an overlay is pending or shown.
REQ-013 digit_code  out  4  nibble for the segment decoder; 4'hF means blank.
REQ-014 dp_n  out  1  decimal point, active-low.
REQ-015 fnd_comm  out  4  digit common, active-low one-hot.

Function
REQ-016 The prescaler SHALL count 0 to SCAN_DIV-1 and wrap, asserting an internal tick for one clk at the wrap.
REQ-017 The 2-bit scan_idx SHALL increment on each tick and wrap 3->0; a frame ends on each 3->0 wrap.
REQ-018 The FSM SHALL have three states: BASE, BLANK and MSG; BLANK records its successor state.
REQ-019 BASE shows the sw_mode-selected source; MSG shows the latched message.
REQ-020 In BASE, msg_req=1 SHALL latch msg_digits, pulse msg_ack on the next clk, and enter BLANK with successor MSG.
REQ-021 In BASE, a change of sw_mode versus its registered copy SHALL enter BLANK with successor BASE.
REQ-022 If msg_req and a sw_mode change occur in the same clk, msg_req SHALL win; the sw_mode copy still updates.
REQ-023 BLANK SHALL last until the next tick, then move to its successor state.
REQ-024 On entering MSG, the frame counter SHALL clear; it increments at each frame end.
REQ-025 When the frame counter reaches MSG_FRAMES at a frame end, the FSM SHALL enter BLANK with successor BASE.
REQ-026 In MSG, msg_req=1 SHALL relatch msg_digits, pulse msg_ack and clear the frame counter, with no BLANK.
REQ-027 msg_busy SHALL be 1 from the clk after latching until the FSM returns to BASE.
REQ-028 Outputs SHALL be registered and update on the clk after a tick or state change.
REQ-029 fnd_comm SHALL drive ~(1<<scan_idx) in BASE and MSG, and 4'b1111 in BLANK.
REQ-030 digit_code SHALL be the scan_idx nibble of the active source in BASE and MSG, and 4'hF in BLANK.
REQ-031 dp_n SHALL be ~dot_en[scan_idx] in BASE, and 1 in MSG and BLANK.

Reset
REQ-032 Reset SHALL clear the prescaler, scan_idx and frame counter, set state BASE, and load the sw_mode copy from sw_mode.
REQ-033 Reset values SHALL be: fnd_comm 4'b1111, digit_code 4'hF, dp_n 1, msg_ack 0, msg_busy 0.
REQ-034 Reset asserted mid-overlay SHALL discard the overlay; display resumes in BASE after the first tick.

Configuration
REQ-035 With FND_LEADING_ZERO_BLANK_EN defined:
- In BASE, digit3 SHALL output 4'hF when its nibble is 0.
- Digit2 SHALL output 4'hF when digits 3 and 2 are both 0.
- Digit1 and digit0 are never blanked.
- MSG is unaffected.
REQ-036 Without FND_LEADING_ZERO_BLANK_EN, all nibbles SHALL pass unmodified.

Verification (SCAN_DIV=4, MSG_FRAMES=2)
REQ-037 Reset release, sw_mode=1, clk_digits=16'h1234 -> fnd_comm cycles 1110,1101,1011,0111 with digit_code 4,3,2,1, one slot every 4 clk.
REQ-038 Pulse msg_req with msg_digits=16'hABCD -> msg_ack one clk later; one blank slot; 8 slots of D,C,B,A; one blank slot; base resumes; msg_busy 0.
REQ-039 Toggle sw_mode 0->1 in BASE -> exactly one slot with fnd_comm 1111, then clk_digits are shown.
REQ-040 msg_req during the second MSG frame -> msg_ack, new message latched, overlay extended to 2 more full frames.
REQ-041 msg_req and a sw_mode toggle in the same clk -> MSG entered; on return, the new sw_mode source is shown.
REQ-042 Macro defined, sw_digits=16'h0045 -> digit_code F,F,4,5 on digits 3..0; same input with macro undefined -> 0,0,4,5.
